axil_read_arbiter: RTL

Two-master AXI4-Lite read-channel arbiter in front of the SPI cache: merges an instruction-fetch port (s0) and a data-load port (s1) onto the single AR/R channel consumed by the cache wrapper. It registers the winning address, forwards it downstream, and steers the single returning R beat back to the granted master. Addresses outside the flash window are answered locally with an error response and never reach the cache.

---
 rtl/spi_cache_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/axil_read_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/spi_cache_pkg.sv
// Shared definitions for the SPI cache front end: arbiter FSM states,
// read-response encodings and the default flash address window width.
package spi_cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  localparam int FLASH_AW_DEFAULT = 24;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; purely combinational, the history bit
// is owned by the caller.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    gnt = 2'b00;
    idx = 1'b0;
    unique case (req)
      2'b01: begin gnt = 2'b01; idx = 1'b0; end
      2'b10: begin gnt = 2'b10; idx = 1'b1; end
      2'b11: begin
        // On a tie the requester that did not win last time goes first.
        if (last) begin gnt = 2'b01; idx = 1'b0; end
        else      begin gnt = 2'b10; idx = 1'b1; end
      end
      default: begin gnt = 2'b00; idx = 1'b0; end
    endcase
  end

endmodule

// File: rtl/axil_read_arbiter.sv
// Two-master AXI4-Lite read arbiter feeding the SPI cache; one transaction
// in flight, out-of-window addresses answered locally with an error.
module axil_read_arbiter
  import spi_cache_pkg::*;
#(
  parameter int FLASH_AW = FLASH_AW_DEFAULT,
  parameter int RESP_W   = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [31:0]       s0_araddr,
  input  logic [2:0]        s0_arprot,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [31:0]       s0_rdata,
  output logic [RESP_W-1:0] s0_rresp,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [31:0]       s1_araddr,
  input  logic [2:0]        s1_arprot,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [31:0]       s1_rdata,
  output logic [RESP_W-1:0] s1_rresp,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [31:0]       m_araddr,
  output logic [2:0]        m_arprot,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  input  logic [RESP_W-1:0] m_rresp
);

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  prot_q, prot_d;

  logic [1:0]        arb_gnt;
  logic              arb_idx;
  logic              r_vld;
  logic [31:0]       r_data;
  logic [RESP_W-1:0] r_resp;
  logic              sel_rready;

  function automatic logic in_window(input logic [31:0] addr);
    return (addr >> FLASH_AW) == 32'd0;
  endfunction

  rr_arbiter2 u_rr (
    .req  ({s1_arvalid, s0_arvalid}),
    .last (last_grant_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  assign sel_rready = grant_q ? s1_rready : s0_rready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    prot_d       = prot_q;
    s0_arready   = 1'b0;
    s1_arready   = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    r_vld        = 1'b0;
    r_data       = 32'h0;
    r_resp       = {RESP_W{RESP_OKAY}};
    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so nothing handshakes while held in reset.
        s0_arready = arb_gnt[0] & aresetn;
        s1_arready = arb_gnt[1] & aresetn;
        if (|arb_gnt) begin
          grant_d = arb_idx;
          addr_d  = arb_idx ? s1_araddr : s0_araddr;
          prot_d  = arb_idx ? s1_arprot : s0_arprot;
          state_d = in_window(arb_idx ? s1_araddr : s0_araddr) ? ADDR : ERR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        r_vld    = m_rvalid;
        r_data   = m_rdata;
        r_resp   = m_rresp;
        m_rready = sel_rready;
        if (m_rvalid && sel_rready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      ERR: begin
        r_vld  = 1'b1;
        r_resp = {RESP_W{RESP_ERR}};
        if (sel_rready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s0_rvalid = r_vld & ~grant_q;
    s1_rvalid = r_vld &  grant_q;
    s0_rdata  = grant_q ? 32'h0 : r_data;
    s1_rdata  = grant_q ? r_data : 32'h0;
    s0_rresp  = grant_q ? {RESP_W{RESP_OKAY}} : r_resp;
    s1_rresp  = grant_q ? r_resp : {RESP_W{RESP_OKAY}};
  end

  assign m_araddr = addr_q;
  assign m_arprot = prot_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= 32'h0;
      prot_q       <= 3'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      prot_q       <= prot_d;
    end
  end

endmodule
